// File: rtl/rtc_bus_xfer_pkg.sv
// rtc_bus_xfer_pkg
// Shared definitions for the RTC bus-cycle engine and the control sequencer
// that feeds it.
//   - xfer_state_t : bus-cycle engine state encoding
//   - RTC_REG_*    : RTC register addresses used by the sequencer paths
//   - phase_load() : counter preload value for a phase of a given length
package rtc_bus_xfer_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        GAP1 = 3'd2,
        DATA = 3'd3,
        GAP2 = 3'd4,
        DONE = 3'd5
    } xfer_state_t;

    // RTC register map
    localparam logic [7:0] RTC_REG_SEC   = 8'h20;
    localparam logic [7:0] RTC_REG_MIN   = 8'h21;
    localparam logic [7:0] RTC_REG_HOUR  = 8'h22;
    localparam logic [7:0] RTC_REG_WDAY  = 8'h23;
    localparam logic [7:0] RTC_REG_DATE  = 8'h24;
    localparam logic [7:0] RTC_REG_MONTH = 8'h25;
    localparam logic [7:0] RTC_REG_YEAR  = 8'h26;
    localparam logic [7:0] RTC_REG_TIMER = 8'h27;
    localparam logic [7:0] RTC_REG_CTRL  = 8'h2E;
    localparam logic [7:0] RTC_REG_INIT  = 8'h2F;

    // The phase counter counts down to zero, so a phase of len cycles
    // is preloaded with len-1.
    function automatic logic [7:0] phase_load(input int unsigned len);
        return 8'(len - 32'd1);
    endfunction

endpackage

// File: rtl/rtc_bus_xfer_if.sv
// rtc_bus_xfer_if
// Groups the transaction handshake (sequencer side) and the multiplexed RTC
// bus pins (pad side) of the bus-cycle engine.
//   Request : start, rw, addr, wdata -> engine ; busy, done, rdata <- engine
//   RTC bus : ad_out, ad_oe, cs_n, rd_n, wr_n, a_d <- engine ; ad_in -> engine
// Modports: slave = the engine, master = sequencer plus pad.
interface rtc_bus_xfer_if;

    logic       start;
    logic       rw;
    logic [7:0] addr;
    logic [7:0] wdata;
    logic       busy;
    logic       done;
    logic [7:0] rdata;
    logic [7:0] ad_out;
    logic       ad_oe;
    logic [7:0] ad_in;
    logic       cs_n;
    logic       rd_n;
    logic       wr_n;
    logic       a_d;

    modport slave (
        input  start, rw, addr, wdata, ad_in,
        output busy, done, rdata, ad_out, ad_oe, cs_n, rd_n, wr_n, a_d
    );

    modport master (
        output start, rw, addr, wdata, ad_in,
        input  busy, done, rdata, ad_out, ad_oe, cs_n, rd_n, wr_n, a_d
    );

endinterface

// File: rtl/rtc_bus_xfer.sv
// rtc_bus_xfer
// Bus-cycle engine for an external RTC on an Intel-style multiplexed AD bus.
// One request (read/write, 8-bit address, 8-bit write data) produces an
// address phase, a gap, a data phase and a second gap, then a one-cycle
// done pulse. Read data is captured at the end of the data phase.
// Ports:
//   clock  : system clock, rising edge
//   reset  : synchronous, active-high
//   bus    : rtc_bus_xfer_if.slave (request handshake + RTC bus pins)
// Parameters:
//   T_PULSE : cycles each strobe phase is active (1..255)
//   T_GAP   : cycles strobes stay inactive after each phase (1..255)
// All outputs are registered and updated together with the state, so each
// output reflects the state being entered on that edge.
module rtc_bus_xfer
    import rtc_bus_xfer_pkg::*;
#(
    parameter int unsigned T_PULSE = 10,
    parameter int unsigned T_GAP   = 7
) (
    input  logic           clock,
    input  logic           reset,
    rtc_bus_xfer_if.slave  bus
);

    xfer_state_t state_r;
    logic [7:0]  count_r;
    logic        rw_q;
    logic [7:0]  addr_q;
    logic [7:0]  wdata_q;

    // Transaction FSM, phase counter and all registered bus/handshake outputs
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r    <= IDLE;
            count_r    <= 8'd0;
            rw_q       <= 1'b0;
            addr_q     <= 8'd0;
            wdata_q    <= 8'd0;
            bus.busy   <= 1'b0;
            bus.done   <= 1'b0;
            bus.rdata  <= 8'd0;
            bus.ad_out <= 8'd0;
            bus.ad_oe  <= 1'b0;
            bus.cs_n   <= 1'b1;
            bus.rd_n   <= 1'b1;
            bus.wr_n   <= 1'b1;
            bus.a_d    <= 1'b1;
        end else begin
            case (state_r)
                IDLE: begin
                    bus.done <= 1'b0;
                    if (bus.start) begin
                        rw_q       <= bus.rw;
                        addr_q     <= bus.addr;
                        wdata_q    <= bus.wdata;
                        count_r    <= phase_load(T_PULSE);
                        state_r    <= ADDR;
                        bus.busy   <= 1'b1;
                        // Address is latched by the RTC on the wr_n strobe
                        // with a_d low, for reads as well as writes.
                        bus.cs_n   <= 1'b0;
                        bus.a_d    <= 1'b0;
                        bus.wr_n   <= 1'b0;
                        bus.rd_n   <= 1'b1;
                        bus.ad_oe  <= 1'b1;
                        bus.ad_out <= bus.addr;
                    end
                end

                ADDR: begin
                    if (count_r != 8'd0) begin
                        count_r <= count_r - 8'd1;
                    end else begin
                        count_r  <= phase_load(T_GAP);
                        state_r  <= GAP1;
                        // ad_oe/ad_out are left alone here: the address stays
                        // driven for one cycle after the strobe rises (hold time).
                        bus.cs_n <= 1'b1;
                        bus.rd_n <= 1'b1;
                        bus.wr_n <= 1'b1;
                        bus.a_d  <= 1'b1;
                    end
                end

                GAP1: begin
                    // Ends the one-cycle address hold; overridden below when
                    // entering a write data phase.
                    bus.ad_oe <= 1'b0;
                    if (count_r != 8'd0) begin
                        count_r <= count_r - 8'd1;
                    end else begin
                        count_r  <= phase_load(T_PULSE);
                        state_r  <= DATA;
                        bus.cs_n <= 1'b0;
                        bus.a_d  <= 1'b1;
                        if (rw_q) begin
                            bus.rd_n  <= 1'b0;
                            bus.wr_n  <= 1'b1;
                            bus.ad_oe <= 1'b0;
                        end else begin
                            bus.rd_n   <= 1'b1;
                            bus.wr_n   <= 1'b0;
                            bus.ad_oe  <= 1'b1;
                            bus.ad_out <= wdata_q;
                        end
                    end
                end

                DATA: begin
                    if (count_r != 8'd0) begin
                        count_r <= count_r - 8'd1;
                    end else begin
                        count_r  <= phase_load(T_GAP);
                        state_r  <= GAP2;
                        bus.cs_n <= 1'b1;
                        bus.rd_n <= 1'b1;
                        bus.wr_n <= 1'b1;
                        // Pad data is still valid on the edge that raises rd_n.
                        if (rw_q) begin
                            bus.rdata <= bus.ad_in;
                        end
                    end
                end

                GAP2: begin
                    // Write data hold: one cycle, then release the bus.
                    bus.ad_oe <= 1'b0;
                    if (count_r != 8'd0) begin
                        count_r <= count_r - 8'd1;
                    end else begin
                        state_r  <= DONE;
                        bus.done <= 1'b1;
                        bus.busy <= 1'b0;
                    end
                end

                DONE: begin
                    // start is not looked at here; it is only honoured in IDLE.
                    bus.done <= 1'b0;
                    state_r  <= IDLE;
                end

                default: begin
                    state_r   <= IDLE;
                    count_r   <= 8'd0;
                    bus.busy  <= 1'b0;
                    bus.done  <= 1'b0;
                    bus.ad_oe <= 1'b0;
                    bus.cs_n  <= 1'b1;
                    bus.rd_n  <= 1'b1;
                    bus.wr_n  <= 1'b1;
                    bus.a_d   <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rtc_bus_xfer.sv
// tb_rtc_bus_xfer
// Self-checking bench for rtc_bus_xfer with T_PULSE=4, T_GAP=3.
// A cycle table derived from the phase timing gives the expected bus pins for
// every cycle of a transaction; expected rdata values go into a scoreboard
// queue when a request is driven and are compared when done pulses.
module tb_rtc_bus_xfer;

    localparam int TP       = 4;
    localparam int TG       = 3;
    localparam int A_END    = TP;
    localparam int G1_END   = TP + TG;
    localparam int D_END    = 2 * TP + TG;
    localparam int G2_END   = 2 * TP + 2 * TG;
    localparam int DONE_CYC = 2 * TP + 2 * TG + 1;

    logic clock;
    logic reset;
    logic [7:0] pad_val;
    logic [7:0] model_rdata;
    logic [7:0] exp_q[$];
    int n_tests;
    int n_fail;

    rtc_bus_xfer_if bus_if ();

    rtc_bus_xfer #(.T_PULSE(TP), .T_GAP(TG)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_if)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Pad model: the RTC drives its data only while rd_n is low.
    assign bus_if.ad_in = (bus_if.rd_n == 1'b0) ? pad_val : 8'hC3;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // {cs_n, rd_n, wr_n, a_d, ad_oe, busy, done} for cycle n after acceptance
    function automatic logic [6:0] exp_bus(input int n, input logic rw);
        if (n <= A_END)       return 7'b0100110;
        else if (n <= G1_END) return {4'b1111, (n == A_END + 1), 2'b10};
        else if (n <= D_END)  return rw ? 7'b0011010 : 7'b0101110;
        else if (n <= G2_END) return {4'b1111, (!rw && n == D_END + 1), 2'b10};
        else if (n == DONE_CYC) return 7'b1111001;
        else                  return 7'b1111000;
    endfunction

    // Scoreboard pop on done, plus bus-safety checks every cycle
    always @(negedge clock) begin
        if (bus_if.done === 1'b1) begin
            check_eq("done_has_request", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check_eq("rdata", 32'(bus_if.rdata), 32'(exp_q.pop_front()));
            end
        end
        check_eq("rd_wr_both_low", 32'(bus_if.rd_n == 1'b0 && bus_if.wr_n == 1'b0), 32'd0);
        check_eq("oe_while_rd", 32'(bus_if.ad_oe == 1'b1 && bus_if.rd_n == 1'b0), 32'd0);
    end

    // One full transaction, checked cycle by cycle through the first idle cycle.
    task automatic do_xfer(input logic t_rw, input logic [7:0] t_addr, input logic [7:0] t_wdata,
                           input logic [7:0] t_rd, input bit hold_start, input bit corrupt);
        logic [6:0] got;
        logic [6:0] exp;
        bus_if.start = 1'b1;
        bus_if.rw    = t_rw;
        bus_if.addr  = t_addr;
        bus_if.wdata = t_wdata;
        pad_val      = t_rd;
        if (t_rw) begin
            model_rdata = t_rd;
        end
        exp_q.push_back(model_rdata);
        for (int n = 1; n <= DONE_CYC + 1; n++) begin
            @(negedge clock);
            exp = exp_bus(n, t_rw);
            got = {bus_if.cs_n, bus_if.rd_n, bus_if.wr_n, bus_if.a_d,
                   bus_if.ad_oe, bus_if.busy, bus_if.done};
            check_eq($sformatf("bus_cyc%0d_rw%0d", n, t_rw), 32'(got), 32'(exp));
            if (exp[2]) begin
                check_eq($sformatf("ad_out_cyc%0d", n), 32'(bus_if.ad_out),
                         32'((n <= A_END + 1) ? t_addr : t_wdata));
            end
            if (!hold_start || n >= DONE_CYC) begin
                bus_if.start = 1'b0;
            end
            if (corrupt && n == A_END + 1) begin
                bus_if.addr  = 8'hFF;
                bus_if.wdata = 8'hFF;
                bus_if.rw    = ~t_rw;
            end
        end
    endtask

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        model_rdata  = 8'h00;
        pad_val      = 8'h00;
        bus_if.start = 1'b0;
        bus_if.rw    = 1'b0;
        bus_if.addr  = 8'h00;
        bus_if.wdata = 8'h00;
        reset        = 1'b1;
        repeat (3) @(negedge clock);

        // Reset state
        check_eq("rst_pins", 32'({bus_if.cs_n, bus_if.rd_n, bus_if.wr_n, bus_if.a_d,
                                  bus_if.ad_oe, bus_if.busy, bus_if.done}), 32'(7'b1111000));
        check_eq("rst_rdata", 32'(bus_if.rdata), 32'd0);
        check_eq("rst_ad_out", 32'(bus_if.ad_out), 32'd0);
        reset = 1'b0;
        @(negedge clock);

        // 1: write, 2: read
        do_xfer(1'b0, 8'h21, 8'h45, 8'h00, 1'b0, 1'b0);
        do_xfer(1'b1, 8'h22, 8'h00, 8'h37, 1'b0, 1'b0);

        // 3: start held high for the whole transaction, then a back-to-back one
        do_xfer(1'b0, 8'h23, 8'h9C, 8'h00, 1'b1, 1'b0);
        check_eq("hold_idle_after", 32'(bus_if.busy), 32'd0);
        do_xfer(1'b1, 8'h24, 8'h00, 8'h6B, 1'b0, 1'b0);

        // 4: request inputs trashed during GAP1
        do_xfer(1'b0, 8'h25, 8'h5E, 8'h00, 1'b0, 1'b1);
        do_xfer(1'b1, 8'h26, 8'h11, 8'hE2, 1'b0, 1'b1);

        // 5: reset in the middle of a read data phase
        bus_if.start = 1'b1;
        bus_if.rw    = 1'b1;
        bus_if.addr  = 8'h22;
        pad_val      = 8'h5A;
        for (int n = 1; n <= G1_END + 2; n++) begin
            @(negedge clock);
            bus_if.start = 1'b0;
        end
        check_eq("rst_mid_in_data", 32'(bus_if.rd_n), 32'd0);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        model_rdata = 8'h00;
        check_eq("rst_mid_pins", 32'({bus_if.cs_n, bus_if.rd_n, bus_if.wr_n,
                                      bus_if.ad_oe, bus_if.busy, bus_if.done}), 32'(6'b111000));
        check_eq("rst_mid_rdata", 32'(bus_if.rdata), 32'd0);
        repeat (DONE_CYC + 2) @(negedge clock);
        check_eq("rst_mid_idle", 32'({bus_if.busy, bus_if.cs_n}), 32'(2'b01));
        do_xfer(1'b1, 8'h27, 8'h00, 8'h99, 1'b0, 1'b0);
        do_xfer(1'b0, 8'h20, 8'h3C, 8'h00, 1'b0, 1'b0);

        // 6: random traffic
        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clock);
            do_xfer(1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom),
                    8'($urandom), 1'b0, 1'b0);
        end

        repeat (3) @(negedge clock);
        check_eq("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
